// File: rtl/ysyx_25020037_wbu_pkg.sv
// ysyx_25020037_wbu_pkg: shared widths, FSM state encoding, mem_size codes
// and the packed write-back bus carried from the WBU to the register file.
// Imported by the interface, the load extender and the WBU top.
package ysyx_25020037_wbu_pkg;

  localparam int XLEN  = 32;  // data width
  localparam int PC_W  = 30;  // word-address PC width (byte PC = {pc, 2'b0})
  localparam int RD_W  = 4;   // GPR index width (16 registers)
  localparam int CSR_W = 3;   // {mtvec, mepc, mstatus} write enables

  typedef enum logic [1:0] {
    WBU_IDLE      = 2'd0,
    WBU_WAIT_LOAD = 2'd1,
    WBU_COMMIT    = 2'd2
  } wbu_state_t;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;  // 2'b11 is also handled as a word

  // Write-back bus towards the GPR/CSR file (wu_to_gu).
  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [RD_W-1:0]  rd;
    logic             gpr_wen;
    logic [XLEN-1:0]  gpr_wdata;
    logic             ecall;
    logic             mret;
    logic [CSR_W-1:0] csr_wen;
    logic [XLEN-1:0]  csr_wdata;
  } wu_bus_t;

endpackage

// File: rtl/ysyx_25020037_wbu_if.sv
// ysyx_25020037_wbu_if: LSU-to-WBU instruction handshake plus the memory
// load-response channel. master = LSU/memory side, slave = WBU side.
// Ports: lsu_valid/wbu_ready handshake, in_* instruction fields, mem_rvalid/mem_rdata.
interface ysyx_25020037_wbu_if;
  import ysyx_25020037_wbu_pkg::*;

  logic             lsu_valid;
  logic             wbu_ready;
  logic [PC_W-1:0]  in_pc;
  logic [RD_W-1:0]  in_rd;
  logic             in_gpr_wen;
  logic [XLEN-1:0]  in_result;
  logic             in_is_load;
  logic [1:0]       in_mem_size;
  logic             in_mem_unsigned;
  logic [1:0]       in_addr_lo;
  logic             in_ecall;
  logic             in_mret;
  logic [CSR_W-1:0] in_csr_wen;
  logic [XLEN-1:0]  in_csr_wdata;
  logic             mem_rvalid;
  logic [XLEN-1:0]  mem_rdata;

  modport master (
    output lsu_valid, in_pc, in_rd, in_gpr_wen, in_result, in_is_load,
           in_mem_size, in_mem_unsigned, in_addr_lo, in_ecall, in_mret,
           in_csr_wen, in_csr_wdata, mem_rvalid, mem_rdata,
    input  wbu_ready
  );

  modport slave (
    input  lsu_valid, in_pc, in_rd, in_gpr_wen, in_result, in_is_load,
           in_mem_size, in_mem_unsigned, in_addr_lo, in_ecall, in_mret,
           in_csr_wen, in_csr_wdata, mem_rvalid, mem_rdata,
    output wbu_ready
  );

endinterface

// File: rtl/ysyx_25020037_load_ext.sv
// ysyx_25020037_load_ext: selects the byte/half/word lane of a raw memory word
// and sign- or zero-extends it. Purely combinational.
// Ports: rdata, size, is_unsigned, addr_lo in; data out.
module ysyx_25020037_load_ext
  import ysyx_25020037_wbu_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[{addr_lo, 3'b000} +: 8];
    // Halves are naturally aligned, so only addr_lo[1] picks the lane.
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    data   = rdata;
    case (size)
      MEM_BYTE: data = is_unsigned ? {{(XLEN-8){1'b0}}, byte_v}
                                   : {{(XLEN-8){byte_v[7]}}, byte_v};
      MEM_HALF: data = is_unsigned ? {{(XLEN-16){1'b0}}, half_v}
                                   : {{(XLEN-16){half_v[15]}}, half_v};
      default:  data = rdata;  // word, and 2'b11 treated as word
    endcase
  end

endmodule

// File: rtl/ysyx_25020037_wbu.sv
// ysyx_25020037_wbu: write-back stage of the multicycle RV32E core. Accepts one
// instruction from the LSU, waits for the load response if needed, extends
// load data and issues a one-cycle commit pulse (wbu_valid) with wu_* fields.
// Ports: clk, rst (async active-high), lsu (slave modport), wbu_valid, wu_* outputs.
// Optional: define WBU_PERF_EN to add perf_retired / perf_load_stall counters.
module ysyx_25020037_wbu
  import ysyx_25020037_wbu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  ysyx_25020037_wbu_if.slave lsu,
  output logic             wbu_valid,
  output logic [PC_W-1:0]  wu_pc,
  output logic [RD_W-1:0]  wu_rd,
  output logic             wu_ecall,
  output logic             wu_mret,
  output logic [CSR_W-1:0] wu_csr_wen,
  output logic [XLEN-1:0]  wu_csr_wdata,
  output logic             wu_gpr_wen,
  output logic [XLEN-1:0]  wu_gpr_wdata
`ifdef WBU_PERF_EN
  ,
  output logic [63:0]      perf_retired,
  output logic [63:0]      perf_load_stall
`endif
);

  wbu_state_t      state;
  logic            ready_q;
  wu_bus_t         wu_q;

  // Load shape captured at accept so WAIT_LOAD does not depend on the LSU
  // still holding its fields.
  logic [1:0]      size_q;
  logic            uns_q;
  logic [1:0]      addr_lo_q;

  logic [1:0]      ext_size;
  logic            ext_uns;
  logic [1:0]      ext_addr_lo;
  logic [XLEN-1:0] ext_data;

  // In IDLE the response may arrive with the instruction itself, so the
  // extender looks at the live fields; otherwise at the captured ones.
  always_comb begin
    ext_size    = size_q;
    ext_uns     = uns_q;
    ext_addr_lo = addr_lo_q;
    if (state == WBU_IDLE) begin
      ext_size    = lsu.in_mem_size;
      ext_uns     = lsu.in_mem_unsigned;
      ext_addr_lo = lsu.in_addr_lo;
    end
  end

  ysyx_25020037_load_ext u_load_ext (
    .rdata       (lsu.mem_rdata),
    .size        (ext_size),
    .is_unsigned (ext_uns),
    .addr_lo     (ext_addr_lo),
    .data        (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WBU_IDLE;
      ready_q   <= 1'b1;
      wbu_valid <= 1'b0;
      wu_q      <= '0;
      size_q    <= MEM_BYTE;
      uns_q     <= 1'b0;
      addr_lo_q <= 2'b00;
    end else begin
      case (state)
        WBU_IDLE: begin
          if (lsu.lsu_valid) begin
            wu_q.pc        <= lsu.in_pc;
            wu_q.rd        <= lsu.in_rd;
            wu_q.gpr_wen   <= lsu.in_gpr_wen;
            wu_q.gpr_wdata <= lsu.in_is_load ? ext_data : lsu.in_result;
            wu_q.ecall     <= lsu.in_ecall;
            wu_q.mret      <= lsu.in_mret;
            wu_q.csr_wen   <= lsu.in_csr_wen;
            wu_q.csr_wdata <= lsu.in_csr_wdata;
            size_q         <= lsu.in_mem_size;
            uns_q          <= lsu.in_mem_unsigned;
            addr_lo_q      <= lsu.in_addr_lo;
            ready_q        <= 1'b0;
            if (!lsu.in_is_load || lsu.mem_rvalid) begin
              state     <= WBU_COMMIT;
              wbu_valid <= 1'b1;
            end else begin
              state <= WBU_WAIT_LOAD;
            end
          end
        end
        WBU_WAIT_LOAD: begin
          if (lsu.mem_rvalid) begin
            wu_q.gpr_wdata <= ext_data;
            wbu_valid      <= 1'b1;
            state          <= WBU_COMMIT;
          end
        end
        WBU_COMMIT: begin
          // Single-cycle pulse; stray mem_rvalid here is ignored.
          wbu_valid <= 1'b0;
          ready_q   <= 1'b1;
          state     <= WBU_IDLE;
        end
        default: begin
          wbu_valid <= 1'b0;
          ready_q   <= 1'b1;
          state     <= WBU_IDLE;
        end
      endcase
    end
  end

  assign lsu.wbu_ready = ready_q;
  assign wu_pc         = wu_q.pc;
  assign wu_rd         = wu_q.rd;
  assign wu_ecall      = wu_q.ecall;
  assign wu_mret       = wu_q.mret;
  assign wu_csr_wen    = wu_q.csr_wen;
  assign wu_csr_wdata  = wu_q.csr_wdata;
  assign wu_gpr_wen    = wu_q.gpr_wen;
  assign wu_gpr_wdata  = wu_q.gpr_wdata;

`ifdef WBU_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_retired    <= 64'd0;
      perf_load_stall <= 64'd0;
    end else begin
      if (wbu_valid) perf_retired <= perf_retired + 64'd1;
      if (state == WBU_WAIT_LOAD) perf_load_stall <= perf_load_stall + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_25020037_wbu.sv
// tb_ysyx_25020037_wbu: directed vectors for the write-back stage. Each issued
// instruction pushes its expected commit (fields + cycle) into a queue; a
// monitor pops and compares on every wbu_valid.
module tb_ysyx_25020037_wbu;
  import ysyx_25020037_wbu_pkg::*;

  logic clk;
  logic rst;
  int   cyc;
  int   tests;
  int   fails;

  ysyx_25020037_wbu_if bus ();

  logic             wbu_valid;
  logic [PC_W-1:0]  wu_pc;
  logic [RD_W-1:0]  wu_rd;
  logic             wu_ecall;
  logic             wu_mret;
  logic [CSR_W-1:0] wu_csr_wen;
  logic [XLEN-1:0]  wu_csr_wdata;
  logic             wu_gpr_wen;
  logic [XLEN-1:0]  wu_gpr_wdata;
`ifdef WBU_PERF_EN
  logic [63:0]      perf_retired;
  logic [63:0]      perf_load_stall;
`endif

  ysyx_25020037_wbu dut (
    .clk          (clk),
    .rst          (rst),
    .lsu          (bus.slave),
    .wbu_valid    (wbu_valid),
    .wu_pc        (wu_pc),
    .wu_rd        (wu_rd),
    .wu_ecall     (wu_ecall),
    .wu_mret      (wu_mret),
    .wu_csr_wen   (wu_csr_wen),
    .wu_csr_wdata (wu_csr_wdata),
    .wu_gpr_wen   (wu_gpr_wen),
    .wu_gpr_wdata (wu_gpr_wdata)
`ifdef WBU_PERF_EN
    ,
    .perf_retired    (perf_retired),
    .perf_load_stall (perf_load_stall)
`endif
  );

  typedef struct {
    logic [PC_W-1:0]  pc;
    logic [RD_W-1:0]  rd;
    logic             gpr_wen;
    logic [XLEN-1:0]  wdata;
    logic             ecall;
    logic             mret;
    logic [CSR_W-1:0] csr_wen;
    logic [XLEN-1:0]  csr_wdata;
    int               at;
  } exp_t;

  exp_t q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endtask

  // Scoreboard monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (!rst && wbu_valid) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_commit: got wbu_valid=1 pc=0x%0h want no commit", wu_pc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (wu_pc !== e.pc || wu_rd !== e.rd || wu_gpr_wen !== e.gpr_wen ||
            wu_gpr_wdata !== e.wdata || wu_ecall !== e.ecall || wu_mret !== e.mret ||
            wu_csr_wen !== e.csr_wen || wu_csr_wdata !== e.csr_wdata ||
            cyc != e.at || bus.wbu_ready !== 1'b0) begin
          fails++;
          $display("FAIL commit: got pc=%h rd=%0d wen=%b wd=%h ec=%b mr=%b cw=%b cd=%h cyc=%0d rdy=%b want pc=%h rd=%0d wen=%b wd=%h ec=%b mr=%b cw=%b cd=%h cyc=%0d rdy=0",
                   wu_pc, wu_rd, wu_gpr_wen, wu_gpr_wdata, wu_ecall, wu_mret, wu_csr_wen,
                   wu_csr_wdata, cyc, bus.wbu_ready, e.pc, e.rd, e.gpr_wen, e.wdata,
                   e.ecall, e.mret, e.csr_wen, e.csr_wdata, e.at);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.lsu_valid       = 1'b0;
    bus.in_pc           = '0;
    bus.in_rd           = '0;
    bus.in_gpr_wen      = 1'b0;
    bus.in_result       = '0;
    bus.in_is_load      = 1'b0;
    bus.in_mem_size     = 2'b00;
    bus.in_mem_unsigned = 1'b0;
    bus.in_addr_lo      = 2'b00;
    bus.in_ecall        = 1'b0;
    bus.in_mret         = 1'b0;
    bus.in_csr_wen      = '0;
    bus.in_csr_wdata    = '0;
    bus.mem_rvalid      = 1'b0;
    bus.mem_rdata       = '0;
  endtask

  // d: load response delay in cycles after the accept cycle (0 = same cycle).
  task automatic send(input logic [PC_W-1:0] pc, input logic [RD_W-1:0] rd,
                      input logic gwen, input logic [31:0] result, input logic ld,
                      input logic [1:0] sz, input logic uns, input logic [1:0] alo,
                      input logic ec, input logic mr, input logic [2:0] cw,
                      input logic [31:0] cd, input int d, input logic [31:0] rdata,
                      input logic [31:0] exp_wd, input bit stray);
    int   n;
    int   t0;
    exp_t e;
    n = 0;
    while (bus.wbu_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (bus.wbu_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got wbu_ready=%b want 1", bus.wbu_ready);
      return;
    end
    bus.in_pc           = pc;
    bus.in_rd           = rd;
    bus.in_gpr_wen      = gwen;
    bus.in_result       = result;
    bus.in_is_load      = ld;
    bus.in_mem_size     = sz;
    bus.in_mem_unsigned = uns;
    bus.in_addr_lo      = alo;
    bus.in_ecall        = ec;
    bus.in_mret         = mr;
    bus.in_csr_wen      = cw;
    bus.in_csr_wdata    = cd;
    bus.lsu_valid       = 1'b1;
    if (ld && d == 0) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rdata;
    end
    t0 = cyc;
    e.pc = pc; e.rd = rd; e.gpr_wen = gwen; e.wdata = exp_wd; e.ecall = ec;
    e.mret = mr; e.csr_wen = cw; e.csr_wdata = cd;
    e.at = t0 + 1 + (ld ? d : 0);
    q.push_back(e);
    step();
    // Scramble the fields so any late reliance on live inputs shows up.
    bus.lsu_valid       = 1'b0;
    bus.mem_rvalid      = 1'b0;
    bus.mem_rdata       = 32'h5A5A_5A5A;
    bus.in_rd           = ~rd;
    bus.in_result       = 32'hDEAD_0000;
    bus.in_mem_size     = 2'b10;
    bus.in_mem_unsigned = ~uns;
    bus.in_addr_lo      = ~alo;
    chk("ready_low_after_accept", {63'd0, bus.wbu_ready}, 64'd0);
    if (stray) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hFFFF_FFFF;
      step();
      bus.mem_rvalid = 1'b0;
      chk("ready_back_after_commit", {63'd0, bus.wbu_ready}, 64'd1);
    end
    if (ld && d > 0) begin
      repeat (d - 1) step();
      chk("ready_low_in_wait", {63'd0, bus.wbu_ready}, 64'd0);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rdata;
      step();
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'h5A5A_5A5A;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    chk("queue_drained", 64'(q.size()), 64'd0);
    repeat (2) step();
  endtask

  initial begin
`ifdef WBU_PERF_EN
    logic [63:0] base_ret;
    logic [63:0] base_stall;
`endif
    tests = 0;
    fails = 0;
    cyc   = 0;
    idle_bus();
    rst = 1'b1;
    #1;
    chk("reset_ready", {63'd0, bus.wbu_ready}, 64'd1);
    chk("reset_valid", {63'd0, wbu_valid}, 64'd0);
    chk("reset_pc", {34'd0, wu_pc}, 64'd0);
    chk("reset_wdata", {32'd0, wu_gpr_wdata}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // pc, rd, wen, result, ld, size, uns, alo, ecall, mret, csr_wen, csr_wdata, d, rdata, exp, stray
    send(30'h40, 4'd5, 1'b1, 32'h0000_1234, 1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000, 32'h0, 0, 32'h0, 32'h0000_1234, 1'b0);
    send(30'h41, 4'd6, 1'b1, 32'h0, 1'b1, 2'b00, 1'b0, 2'd3, 1'b0, 1'b0, 3'b000, 32'h0, 3, 32'h80FF_0000, 32'hFFFF_FF80, 1'b0);
    send(30'h42, 4'd7, 1'b1, 32'h0, 1'b1, 2'b01, 1'b1, 2'd2, 1'b0, 1'b0, 3'b000, 32'h0, 0, 32'hBEEF_1234, 32'h0000_BEEF, 1'b0);
    send(30'h2000_0004, 4'd0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0, 3'b000, 32'h0, 0, 32'h0, 32'h0, 1'b1);
    send(30'h43, 4'd8, 1'b1, 32'h0, 1'b1, 2'b01, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000, 32'h0, 1, 32'h0000_8001, 32'hFFFF_8001, 1'b0);
    send(30'h44, 4'd9, 1'b1, 32'h0, 1'b1, 2'b00, 1'b1, 2'd1, 1'b0, 1'b0, 3'b000, 32'h0, 2, 32'h1234_5678, 32'h0000_0056, 1'b0);
    send(30'h45, 4'd10, 1'b1, 32'h0, 1'b1, 2'b11, 1'b0, 2'd3, 1'b0, 1'b0, 3'b000, 32'h0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    send(30'h46, 4'd11, 1'b1, 32'h0, 1'b1, 2'b01, 1'b0, 2'd3, 1'b0, 1'b0, 3'b000, 32'h0, 1, 32'h8000_1111, 32'hFFFF_8000, 1'b0);
    send(30'h47, 4'd12, 1'b1, 32'h0, 1'b1, 2'b10, 1'b0, 2'd2, 1'b0, 1'b0, 3'b000, 32'h0, 2, 32'h0102_0304, 32'h0102_0304, 1'b0);
    send(30'h48, 4'd0, 1'b0, 32'h8000_0000, 1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b1, 3'b100, 32'hCAFE_0000, 0, 32'h0, 32'h8000_0000, 1'b0);
    send(30'h49, 4'd13, 1'b1, 32'h0, 1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 3'b011, 32'h1357_9BDF, 1, 32'h0000_00FF, 32'hFFFF_FFFF, 1'b0);
    drain();

    // Stray response while idle with no instruction: must not commit.
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1111_1111;
    step();
    bus.mem_rvalid = 1'b0;
    repeat (3) step();
    chk("idle_stray_ready", {63'd0, bus.wbu_ready}, 64'd1);

    // Asynchronous reset while waiting for a load: instruction dropped.
    bus.in_pc      = 30'h77;
    bus.in_rd      = 4'd3;
    bus.in_gpr_wen = 1'b1;
    bus.in_is_load = 1'b1;
    bus.lsu_valid  = 1'b1;
    step();
    bus.lsu_valid = 1'b0;
    bus.in_is_load = 1'b0;
    chk("wait_ready_low", {63'd0, bus.wbu_ready}, 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ready", {63'd0, bus.wbu_ready}, 64'd1);
    chk("arst_valid", {63'd0, wbu_valid}, 64'd0);
    chk("arst_pc", {34'd0, wu_pc}, 64'd0);
    chk("arst_rd", {60'd0, wu_rd}, 64'd0);
    step();
    rst = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h2222_2222;
    step();
    bus.mem_rvalid = 1'b0;
    repeat (3) step();
    send(30'h50, 4'd4, 1'b1, 32'hA5A5_0001, 1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000, 32'h0, 0, 32'h0, 32'hA5A5_0001, 1'b0);
    drain();

    // Ten instructions, two loads stalling four cycles each.
`ifdef WBU_PERF_EN
    base_ret   = perf_retired;
    base_stall = perf_load_stall;
`endif
    for (int i = 0; i < 10; i++) begin
      if (i == 3 || i == 7)
        send(30'(32'h60 + i), 4'(i), 1'b1, 32'h0, 1'b1, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0, 3'b000, 32'h0, 4, 32'h0000_0042 + i, 32'h0000_0042 + i, 1'b0);
      else
        send(30'(32'h60 + i), 4'(i), 1'b1, 32'h100 + i, 1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000, 32'h0, 0, 32'h0, 32'h100 + i, 1'b0);
    end
    drain();
`ifdef WBU_PERF_EN
    chk("perf_retired", perf_retired - base_ret, 64'd10);
    chk("perf_load_stall", perf_load_stall - base_stall, 64'd8);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ysyx_25020037_wbu.md
Name: ysyx_25020037_wbu

Overview:
Write-back stage of the multicycle RV32E core, directly upstream of the GPR/CSR register file. Accepts one retired instruction from the LSU over a valid/ready handshake, waits for the load response where required, and aligns and sign/zero-extends load data. Then drives a one-cycle commit pulse (wbu_valid) with the GPR/CSR write fields. The commit pulse also tells the IFU to fetch the next instruction.

Parameters:
XLEN, 32, data width
PC_W, 30, word-address PC width (byte PC = {pc, 2'b0})
RD_W, 4, GPR index width (16 registers)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
lsu_valid  in  1  LSU holds a valid instruction
wbu_ready  out  1  WBU can accept
in_pc  in  PC_W  instruction PC
in_rd  in  RD_W  destination register
in_gpr_wen  in  1  instruction writes a GPR
in_result  in  XLEN  ALU/CSR-read result for non-loads
in_is_load  in  1  instruction is a load
in_mem_size  in  2  00 byte, 01 half, 10 word
in_mem_unsigned  in  1  zero-extend load
in_addr_lo  in  2  load address bits [1:0]
in_ecall  in  1  ecall
in_mret  in  1  mret
in_csr_wen  in  3  {mtvec, mepc, mstatus} CSR write enables
in_csr_wdata  in  XLEN  CSR write data
mem_rvalid  in  1  load data valid (single-cycle pulse)
mem_rdata  in  XLEN  raw aligned memory word
wbu_valid  out  1  commit pulse
wu_pc, wu_rd, wu_ecall, wu_mret, wu_csr_wen, wu_csr_wdata, wu_gpr_wen  out  matching widths  registered copies of the inputs
wu_gpr_wdata  out  XLEN  final GPR write data

Behaviour:
- Reset (async, rst=1): state IDLE; wbu_valid=0; wbu_ready=1; all wu_* outputs 0.
- State IDLE, wbu_ready=1. On lsu_valid, capture all in_* fields.
  - Non-load: go to COMMIT.
  - Load with mem_rvalid in the same cycle: capture data and go to COMMIT.
  - Load without mem_rvalid: go to WAIT_LOAD.
- State WAIT_LOAD, wbu_ready=0. On mem_rvalid, capture the extended data and go to COMMIT. Otherwise hold.
- State COMMIT, wbu_ready=0. wbu_valid=1 for exactly one cycle with stable wu_* fields, then return to IDLE.
- Latency:
  - Non-load accepted at cycle N: wbu_valid=1 at cycle N+1.
  - Load whose response arrives at cycle M≥N: wbu_valid=1 at cycle M+1.
- Throughput: at most one instruction every 2 cycles.
- Load extraction:
  - byte = rdata[8*addr_lo +: 8].
  - half = addr_lo[1] ? rdata[31:16] : rdata[15:0]; addr_lo[0] is ignored.
  - word = rdata; addr_lo is ignored.
  - mem_size 11 is treated as word.
  - Sign-extend unless in_mem_unsigned.
- wu_gpr_wdata = extracted load data for loads, else in_result.
- wu_gpr_wen passes through unchanged. The GPR file gates writes to rd==0 itself.
- mem_rvalid in IDLE (without a load) or in COMMIT: ignored, no state change.
- lsu_valid while wbu_ready=0: not captured. The LSU must hold its fields stable.
- Reset asserted in WAIT_LOAD or COMMIT: the in-flight instruction is dropped and no commit pulse is produced.

Optional Feature:
Macro WBU_PERF_EN.
- Defined: adds outputs perf_retired[63:0] and perf_load_stall[63:0].
  - perf_retired increments on every wbu_valid.
  - perf_load_stall increments each cycle spent in WAIT_LOAD.
  - Both reset to 0 asynchronously, wrap modulo 2^64, and are registered.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared config package/header holds:
  - state encoding constants WBU_IDLE=2'd0, WBU_WAIT_LOAD=2'd1, WBU_COMMIT=2'd2;
  - mem_size encodings;
  - the wu_to_gu bus field widths.
- Natural sub-module: ysyx_25020037_load_ext, purely combinational: (rdata, size, unsigned, addr_lo) → extended data.
- The FSM and capture registers stay in the top module.

Test Plan:
1. Reset, then non-load ADD: lsu_valid at cycle 0, in_rd=5, in_result=0x1234, gpr_wen=1 → wbu_ready=0 at cycle 1; wbu_valid=1 at cycle 1 with wu_rd=5, wu_gpr_wdata=0x1234; wbu_ready=1 at cycle 2.
2. Signed byte load (size=00, unsigned=0, addr_lo=3): mem_rdata=0x80FF_0000 arrives 3 cycles after accept → stays in WAIT_LOAD 3 cycles; wu_gpr_wdata=0xFFFF_FF80 at response+1.
3. Unsigned half load (addr_lo=2) with rvalid in the same cycle as lsu_valid, rdata=0xBEEF_1234 → commit next cycle with 0x0000_BEEF.
4. ecall with in_pc=0x2000_0004 (word address) and csr_wen=3'b000 → single wbu_valid pulse, wu_ecall=1, wu_pc=0x2000_0004; a stray mem_rvalid during COMMIT changes nothing.
5. rst asserted asynchronously mid-cycle in WAIT_LOAD → outputs clear immediately; no wbu_valid after release; next lsu_valid is accepted normally.
6. With WBU_PERF_EN: 10 instructions, 2 of them loads each stalling 4 cycles → perf_retired=10, perf_load_stall=8.
